// File: rtl/readout_seq_v2.sv
// readout_seq_v2: frame readout sequencer. It steps through NUM_ROW rows starting at
// ROW_START, with NBANK column-bank phases per row. Each phase lasts max(T_PHASE,1) cycles
// and drives the column strobes.
//
// Optional feature: define READOUT_SEQ_ABORT_EN to add abort_i (drop to IDLE from PHASE).
//
// Ports:
//   CLK, rst                   clock (rising edge), async active-high reset
//   trigger_i                  frame-start request, honoured only in IDLE
//   abort_i                    (READOUT_SEQ_ABORT_EN only) abandon the running frame
//   T_PHASE/T_PRECH/T_MUX      phase length, precharge width, mux-start width (cycles)
//   T_DLY/T_FAST               fast-clock start delay and period (cycles)
//   ROW_START/NUM_ROW          first row and rows per frame
//   re_busy, done_o            frame in progress / one-cycle completion pulse
//   ROWADD, BANK_SEL           current row, one-hot active bank
//   COL_PRECH, MUX_START, CP_MUX_IN  column strobes
module readout_seq_v2 #(
    parameter int unsigned ROW_W = 10,
    parameter int unsigned TW    = 16,
    parameter int unsigned NBANK = 2
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             trigger_i,
`ifdef READOUT_SEQ_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic [TW-1:0]    T_PHASE,
    input  logic [TW-1:0]    T_PRECH,
    input  logic [TW-1:0]    T_MUX,
    input  logic [TW-1:0]    T_DLY,
    input  logic [TW-1:0]    T_FAST,
    input  logic [ROW_W-1:0] ROW_START,
    input  logic [ROW_W-1:0] NUM_ROW,
    output logic             re_busy,
    output logic             done_o,
    output logic [ROW_W-1:0] ROWADD,
    output logic [NBANK-1:0] BANK_SEL,
    output logic             COL_PRECH,
    output logic             MUX_START,
    output logic             CP_MUX_IN
);
    localparam int unsigned BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

    typedef enum logic {S_IDLE, S_PHASE} state_t;

    state_t             r_state, w_nxt_state;
    logic [BANK_W-1:0]  r_bank, w_nxt_bank;
    logic [TW-1:0]      r_ph, w_nxt_ph;
    logic [TW-1:0]      r_dly, w_nxt_dly;
    logic [TW-1:0]      r_fast, w_nxt_fast;
    logic [ROW_W-1:0]   r_row_cnt, w_nxt_row_cnt;
    logic [ROW_W-1:0]   r_rowadd, w_nxt_rowadd;

    // Frame configuration captured on the accepting edge
    logic [TW-1:0]      r_cfg_phase, r_cfg_prech, r_cfg_mux, r_cfg_dly, r_cfg_fast;
    logic [TW-1:0]      w_cfg_phase, w_cfg_prech, w_cfg_mux, w_cfg_dly, w_cfg_fast;
    logic [ROW_W-1:0]   r_cfg_nrow, w_cfg_nrow;

    // Registered outputs
    logic               r_busy, r_done, r_prech, r_mux, r_cp;
    logic [NBANK-1:0]   r_bank_sel;
    logic               w_busy, w_done, w_prech, w_mux, w_cp;
    logic [NBANK-1:0]   w_bank_sel;

    logic               w_abort;
    logic [TW-1:0]      w_ph_last;

`ifdef READOUT_SEQ_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    // Last timer value of a phase; T_PHASE=0 behaves as a 1-cycle phase
    assign w_ph_last = (r_cfg_phase == '0) ? '0 : r_cfg_phase - TW'(1);

    // State register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bank      <= '0;
            r_ph        <= '0;
            r_dly       <= '0;
            r_fast      <= '0;
            r_row_cnt   <= '0;
            r_rowadd    <= '0;
            r_cfg_phase <= '0;
            r_cfg_prech <= '0;
            r_cfg_mux   <= '0;
            r_cfg_dly   <= '0;
            r_cfg_fast  <= '0;
            r_cfg_nrow  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_prech     <= 1'b0;
            r_mux       <= 1'b0;
            r_cp        <= 1'b0;
            r_bank_sel  <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_bank      <= w_nxt_bank;
            r_ph        <= w_nxt_ph;
            r_dly       <= w_nxt_dly;
            r_fast      <= w_nxt_fast;
            r_row_cnt   <= w_nxt_row_cnt;
            r_rowadd    <= w_nxt_rowadd;
            r_cfg_phase <= w_cfg_phase;
            r_cfg_prech <= w_cfg_prech;
            r_cfg_mux   <= w_cfg_mux;
            r_cfg_dly   <= w_cfg_dly;
            r_cfg_fast  <= w_cfg_fast;
            r_cfg_nrow  <= w_cfg_nrow;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_prech     <= w_prech;
            r_mux       <= w_mux;
            r_cp        <= w_cp;
            r_bank_sel  <= w_bank_sel;
        end
    end

    // Next state; outputs are decoded from the next state so the registered
    // outputs line up with the state they describe
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_bank    = r_bank;
        w_nxt_ph      = r_ph;
        w_nxt_dly     = r_dly;
        w_nxt_fast    = r_fast;
        w_nxt_row_cnt = r_row_cnt;
        w_nxt_rowadd  = r_rowadd;
        w_cfg_phase   = r_cfg_phase;
        w_cfg_prech   = r_cfg_prech;
        w_cfg_mux     = r_cfg_mux;
        w_cfg_dly     = r_cfg_dly;
        w_cfg_fast    = r_cfg_fast;
        w_cfg_nrow    = r_cfg_nrow;
        w_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (trigger_i) begin
                    w_cfg_phase   = T_PHASE;
                    w_cfg_prech   = T_PRECH;
                    w_cfg_mux     = T_MUX;
                    w_cfg_dly     = T_DLY;
                    w_cfg_fast    = T_FAST;
                    w_cfg_nrow    = NUM_ROW;
                    w_nxt_bank    = '0;
                    w_nxt_ph      = '0;
                    w_nxt_dly     = '0;
                    w_nxt_fast    = '0;
                    w_nxt_row_cnt = '0;
                    // An empty frame completes immediately and leaves ROWADD alone
                    if (NUM_ROW == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_nxt_state  = S_PHASE;
                        w_nxt_rowadd = ROW_START;
                    end
                end
            end
            S_PHASE: begin
                if (w_abort) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_bank  = '0;
                    w_nxt_ph    = '0;
                    w_nxt_dly   = '0;
                    w_nxt_fast  = '0;
                end else if (r_ph == w_ph_last) begin
                    w_nxt_ph   = '0;
                    w_nxt_dly  = '0;
                    w_nxt_fast = '0;
                    if (r_bank == BANK_W'(NBANK - 1)) begin
                        w_nxt_bank = '0;
                        if (r_row_cnt == r_cfg_nrow - ROW_W'(1)) begin
                            w_nxt_state = S_IDLE;
                            w_done      = 1'b1;
                        end else begin
                            w_nxt_row_cnt = r_row_cnt + ROW_W'(1);
                            w_nxt_rowadd  = r_rowadd + ROW_W'(1);
                        end
                    end else begin
                        w_nxt_bank = r_bank + BANK_W'(1);
                    end
                end else begin
                    w_nxt_ph = r_ph + TW'(1);
                    // Delay counts up to T_DLY, then the fast timer cycles 0..T_FAST-1
                    if (r_dly != r_cfg_dly) begin
                        w_nxt_dly = r_dly + TW'(1);
                    end else if ((r_cfg_fast < TW'(2)) || (r_fast >= r_cfg_fast - TW'(1))) begin
                        w_nxt_fast = '0;
                    end else begin
                        w_nxt_fast = r_fast + TW'(1);
                    end
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase

        w_busy     = (w_nxt_state == S_PHASE);
        w_bank_sel = w_busy ? (NBANK'(1) << w_nxt_bank) : '0;
        w_prech    = w_busy && (w_nxt_ph < w_cfg_prech);
        w_mux      = w_busy && (w_nxt_ph < w_cfg_mux);
        w_cp       = w_busy && (w_cfg_fast >= TW'(2)) && (w_nxt_dly == w_cfg_dly)
                     && (w_nxt_fast < (w_cfg_fast >> 1));
    end

    assign re_busy   = r_busy;
    assign done_o    = r_done;
    assign ROWADD    = r_rowadd;
    assign BANK_SEL  = r_bank_sel;
    assign COL_PRECH = r_prech;
    assign MUX_START = r_mux;
    assign CP_MUX_IN = r_cp;

endmodule

// File: tb/tb_readout_seq_v2.sv
// Self-checking bench for readout_seq_v2. The reference model derives every output
// from the frame cycle index with plain arithmetic (phase = c / plen, t = c % plen).
module tb_readout_seq_v2;
    localparam int ROW_W = 4;
    localparam int TW    = 8;
    localparam int NB    = 2;
    localparam int VW    = 3 + NB + ROW_W + 3;

    logic             CLK = 1'b0;
    logic             rst;
    logic             trigger_i;
`ifdef READOUT_SEQ_ABORT_EN
    logic             abort_i;
`endif
    logic [TW-1:0]    T_PHASE, T_PRECH, T_MUX, T_DLY, T_FAST;
    logic [ROW_W-1:0] ROW_START, NUM_ROW;
    logic             re_busy, done_o, COL_PRECH, MUX_START, CP_MUX_IN;
    logic [ROW_W-1:0] ROWADD;
    logic [NB-1:0]    BANK_SEL;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Model configuration of the current frame; m_hold is ROWADD before the frame
    int m_tph, m_tpre, m_tmux, m_tdly, m_tfast, m_rs, m_nrow, m_hold;

    readout_seq_v2 #(.ROW_W(ROW_W), .TW(TW), .NBANK(NB)) dut (
        .CLK(CLK), .rst(rst), .trigger_i(trigger_i),
`ifdef READOUT_SEQ_ABORT_EN
        .abort_i(abort_i),
`endif
        .T_PHASE(T_PHASE), .T_PRECH(T_PRECH), .T_MUX(T_MUX), .T_DLY(T_DLY), .T_FAST(T_FAST),
        .ROW_START(ROW_START), .NUM_ROW(NUM_ROW),
        .re_busy(re_busy), .done_o(done_o), .ROWADD(ROWADD), .BANK_SEL(BANK_SEL),
        .COL_PRECH(COL_PRECH), .MUX_START(MUX_START), .CP_MUX_IN(CP_MUX_IN)
    );

    always #5 CLK = ~CLK;

    function automatic logic [VW-1:0] obs();
        return {done_o, re_busy, BANK_SEL, ROWADD, COL_PRECH, MUX_START, CP_MUX_IN};
    endfunction

    function automatic int flen();
        int plen;
        plen = (m_tph == 0) ? 1 : m_tph;
        return m_nrow * NB * plen;
    endfunction

    // Expected outputs c cycles after the accepting edge (c=0 is the first frame cycle)
    function automatic logic [VW-1:0] model(input int c);
        int plen, total, ph, t;
        logic d, b, p, m, cp;
        logic [NB-1:0] bs;
        logic [ROW_W-1:0] ra;
        plen  = (m_tph == 0) ? 1 : m_tph;
        total = m_nrow * NB * plen;
        d = 1'b0; b = 1'b0; p = 1'b0; m = 1'b0; cp = 1'b0; bs = '0;
        ra = ROW_W'(m_hold);
        if (c < total) begin
            ph = c / plen;
            t  = c % plen;
            b  = 1'b1;
            bs = NB'(1) << (ph % NB);
            ra = ROW_W'(m_rs + ph / NB);
            p  = (t < m_tpre);
            m  = (t < m_tmux);
            cp = (m_tfast >= 2) && (t >= m_tdly) && (((t - m_tdly) % m_tfast) < (m_tfast / 2));
        end else begin
            d = (c == total);
            if (m_nrow > 0) ra = ROW_W'(m_rs + m_nrow - 1);
        end
        return {d, b, bs, ra, p, m, cp};
    endfunction

    // Present a frame request for one edge, then scramble inputs to prove they were latched
    task automatic start(input bit rel_rst, input int tph, tpre, tmux, tdly, tfast, rs, nr);
        m_tph = tph; m_tpre = tpre; m_tmux = tmux; m_tdly = tdly; m_tfast = tfast;
        m_rs = rs; m_nrow = nr;
        @(negedge CLK);
        if (rel_rst) rst = 1'b0;
        T_PHASE = TW'(tph); T_PRECH = TW'(tpre); T_MUX = TW'(tmux);
        T_DLY = TW'(tdly); T_FAST = TW'(tfast);
        ROW_START = ROW_W'(rs); NUM_ROW = ROW_W'(nr);
        trigger_i = 1'b1;
        @(negedge CLK);
        trigger_i = 1'b0;
        T_PHASE = TW'($urandom_range(0, 9)); T_PRECH = TW'($urandom_range(0, 9));
        T_MUX = TW'($urandom_range(0, 9)); T_DLY = TW'($urandom_range(0, 9));
        T_FAST = TW'($urandom_range(0, 9));
        ROW_START = ROW_W'($urandom); NUM_ROW = ROW_W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; trigger_i = 1'b1;
        repeat (2) @(negedge CLK);
        total_cnt++;
        if (obs() !== '0) begin
            bad_cnt++; $display("FAIL reset_state got=%b exp=%b", obs(), {VW{1'b0}});
        end
        rst = 1'b0; trigger_i = 1'b0;
        @(negedge CLK);
        total_cnt++;
        if (obs() !== '0) begin
            bad_cnt++; $display("FAIL reset_release got=%b exp=%b", obs(), {VW{1'b0}});
        end
        m_hold = 0;
    endtask

    task automatic test_row_sequence();
        logic [ROW_W-1:0] exp_ra [6];
        int busy_n, done_n;
        exp_ra = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7};
        busy_n = 0; done_n = 0;
        start(1'b0, 4, 2, 1, 0, 2, 5, 3);
        for (int c = 0; c < 28; c++) begin
            total_cnt++;
            if (obs() !== model(c)) begin
                bad_cnt++; $display("FAIL row_seq_cycle c=%0d got=%b exp=%b", c, obs(), model(c));
            end
            if (c < 24 && (c % 4) == 0) begin
                total_cnt++;
                if (ROWADD !== exp_ra[c / 4]) begin
                    bad_cnt++; $display("FAIL row_seq_rowadd phase=%0d got=%0d exp=%0d", c / 4, ROWADD, exp_ra[c / 4]);
                end
            end
            if (re_busy) busy_n++;
            if (done_o) done_n++;
            @(negedge CLK);
        end
        total_cnt++;
        if (busy_n != 24 || done_n != 1) begin
            bad_cnt++; $display("FAIL row_seq_counts busy=%0d done=%0d exp busy=24 done=1", busy_n, done_n);
        end
        m_hold = 7;
    endtask

    task automatic test_strobes();
        logic [7:0] pre_t, mux_t, cp_t;
        logic [2:0] exp_s;
        pre_t = 8'b1100_0000; mux_t = 8'b1000_0000; cp_t = 8'b0110_0110;
        start(1'b0, 8, 2, 1, 1, 4, 3, 1);
        for (int c = 0; c < 16; c++) begin
            exp_s = {pre_t[7 - c % 8], mux_t[7 - c % 8], cp_t[7 - c % 8]};
            total_cnt++;
            if ({COL_PRECH, MUX_START, CP_MUX_IN} !== exp_s) begin
                bad_cnt++; $display("FAIL strobes c=%0d got=%b exp=%b", c, {COL_PRECH, MUX_START, CP_MUX_IN}, exp_s);
            end
            @(negedge CLK);
        end
        total_cnt++;
        if (obs() !== model(16)) begin
            bad_cnt++; $display("FAIL strobes_done got=%b exp=%b", obs(), model(16));
        end
        m_hold = 3;
    endtask

    task automatic test_row_wrap();
        int busy_after;
        busy_after = 0;
        start(1'b0, 2, 1, 0, 0, 0, 15, 2);
        for (int c = 0; c < 8; c++) begin
            total_cnt++;
            if (ROWADD !== ((c < 4) ? 4'd15 : 4'd0) || re_busy !== 1'b1) begin
                bad_cnt++; $display("FAIL row_wrap c=%0d got row=%0d busy=%b exp row=%0d busy=1", c, ROWADD, re_busy, (c < 4) ? 15 : 0);
            end
            trigger_i = (c == 3);
            @(negedge CLK);
        end
        trigger_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (re_busy) busy_after++;
            @(negedge CLK);
        end
        total_cnt++;
        if (busy_after != 0) begin
            bad_cnt++; $display("FAIL row_wrap_no_refire busy_cycles=%0d exp=0", busy_after);
        end
        m_hold = 0;
    endtask

    task automatic test_zero_cases();
        start(1'b0, 3, 1, 1, 0, 2, 9, 0);
        total_cnt++;
        if ({done_o, re_busy, BANK_SEL} !== {1'b1, 1'b0, {NB{1'b0}}}) begin
            bad_cnt++; $display("FAIL zero_rows_done got=%b exp=%b", {done_o, re_busy, BANK_SEL}, {1'b1, 1'b0, {NB{1'b0}}});
        end
        @(negedge CLK);
        total_cnt++;
        if ({done_o, re_busy, BANK_SEL} !== '0) begin
            bad_cnt++; $display("FAIL zero_rows_after got=%b exp=0", {done_o, re_busy, BANK_SEL});
        end
        start(1'b0, 0, 1, 1, 0, 0, 12, 2);
        for (int c = 0; c <= 5; c++) begin
            total_cnt++;
            if (obs() !== model(c)) begin
                bad_cnt++; $display("FAIL zero_phase c=%0d got=%b exp=%b", c, obs(), model(c));
            end
            @(negedge CLK);
        end
        m_hold = 13;
    endtask

    task automatic test_reset_mid_frame();
        int seen;
        seen = 0;
        start(1'b0, 3, 1, 1, 0, 3, 2, 3);
        for (int c = 0; c < 10; c++) begin
            total_cnt++;
            if (obs() !== model(c)) begin
                bad_cnt++; $display("FAIL rst_mid_pre c=%0d got=%b exp=%b", c, obs(), model(c));
            end
            @(negedge CLK);
        end
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (obs() !== '0) begin
            bad_cnt++; $display("FAIL rst_mid_async got=%b exp=0", obs());
        end
        repeat (3) begin
            @(negedge CLK);
            if (done_o || re_busy) seen++;
        end
        total_cnt++;
        if (seen != 0) begin
            bad_cnt++; $display("FAIL rst_mid_quiet active_cycles=%0d exp=0", seen);
        end
        m_hold = 0;
        start(1'b1, 2, 1, 2, 1, 2, 9, 1);
        for (int c = 0; c <= 5; c++) begin
            total_cnt++;
            if (obs() !== model(c)) begin
                bad_cnt++; $display("FAIL rst_mid_retrig c=%0d got=%b exp=%b", c, obs(), model(c));
            end
            @(negedge CLK);
        end
        m_hold = 9;
    endtask

`ifdef READOUT_SEQ_ABORT_EN
    task automatic test_abort();
        int seen;
        seen = 0;
        start(1'b0, 3, 1, 1, 0, 2, 4, 3);
        for (int c = 0; c < 8; c++) begin
            if (c == 7) abort_i = 1'b1;
            total_cnt++;
            if (obs() !== model(c)) begin
                bad_cnt++; $display("FAIL abort_pre c=%0d got=%b exp=%b", c, obs(), model(c));
            end
            @(negedge CLK);
        end
        abort_i = 1'b0;
        total_cnt++;
        if ({done_o, re_busy, BANK_SEL, COL_PRECH, MUX_START, CP_MUX_IN} !== '0) begin
            bad_cnt++; $display("FAIL abort_idle got=%b exp=0", {done_o, re_busy, BANK_SEL, COL_PRECH, MUX_START, CP_MUX_IN});
        end
        repeat (4) begin
            @(negedge CLK);
            if (done_o || re_busy) seen++;
        end
        total_cnt++;
        if (seen != 0) begin
            bad_cnt++; $display("FAIL abort_no_done active_cycles=%0d exp=0", seen);
        end
        m_hold = 5;
        abort_i = 1'b1;
        start(1'b0, 2, 1, 1, 0, 2, 6, 1);
        abort_i = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            total_cnt++;
            if (obs() !== model(c)) begin
                bad_cnt++; $display("FAIL abort_idle_ignored c=%0d got=%b exp=%b", c, obs(), model(c));
            end
            @(negedge CLK);
        end
        m_hold = 6;
    endtask
`endif

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            start(1'b0, $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 6),
                  $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 3));
            for (int c = 0; c <= flen() + 1; c++) begin
                total_cnt++;
                if (obs() !== model(c)) begin
                    bad_cnt++; $display("FAIL random f=%0d c=%0d got=%b exp=%b", f, c, obs(), model(c));
                end
                trigger_i = (c < flen()) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge CLK);
            end
            if (m_nrow > 0) m_hold = (m_rs + m_nrow - 1) % 16;
        end
    endtask

    initial begin
        rst = 1'b1; trigger_i = 1'b0;
`ifdef READOUT_SEQ_ABORT_EN
        abort_i = 1'b0;
`endif
        T_PHASE = '0; T_PRECH = '0; T_MUX = '0; T_DLY = '0; T_FAST = '0;
        ROW_START = '0; NUM_ROW = '0;
        m_hold = 0;
        test_reset();
        test_row_sequence();
        test_strobes();
        test_row_wrap();
        test_zero_cases();
        test_reset_mid_frame();
`ifdef READOUT_SEQ_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total_cnt, bad_cnt);
        $fatal(1);
    end

endmodule
